// File: rtl/num2str_stream_if.sv
// Handshake bundle for num2str_stream: binary sample in, fixed-width character string out.
interface num2str_stream_if #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_NUM    = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_WIDTH-1:0]   data_in;
    logic                    signed_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [MAX_NUM*8-1:0]    data_out;
    logic                    overflow;

    modport master (
        output in_valid, data_in, signed_in, out_ready,
        input  in_ready, out_valid, data_out, overflow
    );

    modport slave (
        input  in_valid, data_in, signed_in, out_ready,
        output in_ready, out_valid, data_out, overflow
    );
endinterface

// File: rtl/num2str_stream.sv
// Streaming binary-to-ASCII decimal converter, one character slot per clock.
// Signed input support is compiled in when NUM2STR_SIGNED_EN is defined.
module num2str_stream #(
    parameter int         DATA_WIDTH    = 32,
    parameter int         MAX_NUM       = 8,
    parameter int         FRAC_DIGITS   = 0,
    parameter int         LEADING_ZEROS = 0,
    parameter logic [7:0] PAD_CHAR      = 8'hFF
) (
    input  logic            clk,
    input  logic            rst_n,
    num2str_stream_if.slave bus
);
    localparam int SW         = $clog2(MAX_NUM + 1);
    localparam int MIN_DIGITS = (FRAC_DIGITS > 0) ? FRAC_DIGITS + 2 : 1;
    localparam logic [SW-1:0] LAST_SLOT = SW'(MAX_NUM - 1);
    localparam logic [SW-1:0] POINT_SLOT = SW'(FRAC_DIGITS);
    localparam logic [SW-1:0] MIN_SLOTS  = SW'(MIN_DIGITS);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t                  state;
    logic [SW-1:0]           s;
    logic                    ready;
    logic                    valid;
    logic [MAX_NUM*8-1:0]    result;
    logic                    result_ovf;

    logic [DATA_WIDTH-1:0]   work;
    logic [DATA_WIDTH-1:0]   work_next;
    logic [MAX_NUM*8-1:0]    shadow;
    logic [MAX_NUM*8-1:0]    shadow_next;
    logic [DATA_WIDTH-1:0]   load_value;
    logic [7:0]              slot_char;
    logic                    sign_set;
    logic                    ovf_next;
    logic                    accept;
    logic                    neg;
    logic                    sgn;
    logic                    sign_done;

    function automatic logic [7:0] ascii_digit(input logic [DATA_WIDTH-1:0] value);
        logic [DATA_WIDTH-1:0] rem;
        rem = value % DATA_WIDTH'(10);
        return 8'h30 + {4'h0, rem[3:0]};
    endfunction

    assign accept = (state == IDLE) && bus.in_valid;

`ifdef NUM2STR_SIGNED_EN
    logic signed [DATA_WIDTH-1:0] sample;

    // Two's complement magnitude; the most negative value maps to 2^(W-1) as unsigned.
    function automatic logic [DATA_WIDTH-1:0] magnitude(input logic signed [DATA_WIDTH-1:0] value);
        logic signed [DATA_WIDTH-1:0] negated;
        negated = -value;
        return (value < 0) ? $unsigned(negated) : $unsigned(value);
    endfunction

    assign sample     = bus.data_in;
    assign load_value = bus.signed_in ? magnitude(sample) : bus.data_in;

    always_ff @(posedge clk) begin
        if (accept) begin
            neg       <= bus.signed_in & sample[DATA_WIDTH-1];
            sgn       <= bus.signed_in;
            sign_done <= 1'b0;
        end else if (state == CONV) begin
            sign_done <= sign_done | sign_set;
        end
    end
`else
    logic unused_signed;

    assign load_value    = bus.data_in;
    assign neg           = 1'b0;
    assign sgn           = 1'b0;
    assign sign_done     = 1'b0;
    assign unused_signed = bus.signed_in;
`endif

    // Character for the current slot, in priority order: point, sign slot, digit, sign, pad.
    always_comb begin
        slot_char = PAD_CHAR;
        work_next = work;
        sign_set  = 1'b0;
        if (FRAC_DIGITS > 0 && s == POINT_SLOT) begin
            slot_char = 8'h2E;
        end else if (LEADING_ZEROS != 0 && sgn && s == LAST_SLOT) begin
            slot_char = neg ? 8'h2D : PAD_CHAR;
            sign_set  = neg;
        end else if (work != '0 || s < MIN_SLOTS || LEADING_ZEROS != 0) begin
            slot_char = ascii_digit(work);
            work_next = work / DATA_WIDTH'(10);
        end else if (neg && !sign_done) begin
            slot_char = 8'h2D;
            sign_set  = 1'b1;
        end
        shadow_next            = shadow;
        shadow_next[8*s +: 8]  = slot_char;
        ovf_next               = (work_next != '0) | (neg & ~(sign_done | sign_set));
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            work <= load_value;
        end else if (state == CONV) begin
            work   <= work_next;
            shadow <= shadow_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            s          <= '0;
            ready      <= 1'b1;
            valid      <= 1'b0;
            result_ovf <= 1'b0;
            result     <= {MAX_NUM{PAD_CHAR}};
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        state <= CONV;
                        s     <= '0;
                        ready <= 1'b0;
                    end
                end
                CONV: begin
                    s <= s + 1'b1;
                    if (s == LAST_SLOT) begin
                        state      <= DONE;
                        valid      <= 1'b1;
                        result     <= shadow_next;
                        result_ovf <= ovf_next;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                        valid <= 1'b0;
                        ready <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = valid;
    assign bus.data_out  = result;
    assign bus.overflow  = result_ovf;
endmodule

// File: tb/tb_num2str_stream.sv
// Bench for num2str_stream: four configurations driven in lockstep against a string-building model.
module tb_num2str_stream;
`ifdef NUM2STR_SIGNED_EN
    localparam bit SEN = 1'b1;
`else
    localparam bit SEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] data_in;
    logic        signed_in;
    logic        out_ready;
    int          comps = 0;
    int          fails = 0;

    logic [3:0]  ov;
    logic [3:0]  rdy;
    logic [3:0]  ofl;
    logic [95:0] dout [4];
    logic [95:0] cap  [4];
    logic        capo [4];
    int          lat  [4];

    always #5 clk = ~clk;

    num2str_stream_if #(.DATA_WIDTH(32), .MAX_NUM(8))  b0 ();
    num2str_stream_if #(.DATA_WIDTH(32), .MAX_NUM(8))  b1 ();
    num2str_stream_if #(.DATA_WIDTH(32), .MAX_NUM(12)) b2 ();
    num2str_stream_if #(.DATA_WIDTH(32), .MAX_NUM(8))  b3 ();

    num2str_stream #(.MAX_NUM(8))                    u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    num2str_stream #(.MAX_NUM(8), .LEADING_ZEROS(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    num2str_stream #(.MAX_NUM(12))                   u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    num2str_stream #(.MAX_NUM(8), .FRAC_DIGITS(2))   u3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    assign b0.in_valid = in_valid;  assign b0.data_in = data_in;
    assign b0.signed_in = signed_in; assign b0.out_ready = out_ready;
    assign b1.in_valid = in_valid;  assign b1.data_in = data_in;
    assign b1.signed_in = signed_in; assign b1.out_ready = out_ready;
    assign b2.in_valid = in_valid;  assign b2.data_in = data_in;
    assign b2.signed_in = signed_in; assign b2.out_ready = out_ready;
    assign b3.in_valid = in_valid;  assign b3.data_in = data_in;
    assign b3.signed_in = signed_in; assign b3.out_ready = out_ready;

    assign ov  = {b3.out_valid, b2.out_valid, b1.out_valid, b0.out_valid};
    assign rdy = {b3.in_ready, b2.in_ready, b1.in_ready, b0.in_ready};
    assign ofl = {b3.overflow, b2.overflow, b1.overflow, b0.overflow};
    assign dout[0] = {32'h0, b0.data_out};
    assign dout[1] = {32'h0, b1.data_out};
    assign dout[2] = b2.data_out;
    assign dout[3] = {32'h0, b3.data_out};

    function automatic int cfg_max(input int k);
        return (k == 2) ? 12 : 8;
    endfunction

    function automatic int cfg_frac(input int k);
        return (k == 3) ? 2 : 0;
    endfunction

    function automatic bit cfg_lz(input int k);
        return (k == 1);
    endfunction

    // Reference: build the string right-to-left as a character queue, then fit it into the slots.
    function automatic void model(input int k, input logic [31:0] d, input logic sg,
                                  output logic [95:0] str, output logic ovf);
        int maxn, frac, nd, mind;
        bit lz, sm, neg;
        longint unsigned mag, p;
        logic [7:0] q[$];
        maxn = cfg_max(k);
        frac = cfg_frac(k);
        lz   = cfg_lz(k);
        sm   = SEN && sg;
        neg  = sm && d[31];
        mag  = neg ? (64'h1_0000_0000 - {32'h0, d}) : {32'h0, d};
        mind = (frac > 0) ? frac + 1 : 1;
        if (lz) begin
            nd = maxn - ((frac > 0) ? 1 : 0) - (sm ? 1 : 0);
        end else begin
            nd = 1;
            p  = 10;
            while (mag >= p) begin
                nd++;
                p = p * 10;
            end
            if (nd < mind) nd = mind;
        end
        p = 1;
        for (int i = 0; i < nd; i++) begin
            if (frac > 0 && q.size() == frac) q.push_back(8'h2E);
            q.push_back(8'h30 + 8'((mag / p) % 10));
            p = p * 10;
        end
        ovf = (mag >= p);
        if (lz && sm) q.push_back(neg ? 8'h2D : 8'hFF);
        else if (neg) q.push_back(8'h2D);
        if (q.size() > maxn) ovf = 1'b1;
        str = '0;
        for (int i = 0; i < maxn; i++) str[i*8 +: 8] = (i < q.size()) ? q[i] : 8'hFF;
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] want);
        comps++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, want);
        end
    endtask

    // Apply one sample to all four converters and check every result against the model.
    task automatic run_vec(input logic [31:0] d, input logic sg, input string tag);
        int cnt;
        logic [3:0]  got;
        logic [95:0] e;
        logic        eo;
        cnt = 0;
        @(negedge clk);
        while (rdy != 4'hF && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, " idle"}, {92'h0, rdy}, 96'hF);
        data_in   = d;
        signed_in = sg;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        got = '0;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            cap[k]  = 'x;
            capo[k] = 1'bx;
            lat[k]  = 0;
        end
        while (got != 4'hF && cnt < 30) begin
            @(negedge clk);
            cnt++;
            for (int k = 0; k < 4; k++) begin
                if (!got[k] && ov[k]) begin
                    got[k]  = 1'b1;
                    cap[k]  = dout[k];
                    capo[k] = ofl[k];
                    lat[k]  = cnt;
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            model(k, d, sg, e, eo);
            check($sformatf("%s u%0d data", tag, k), cap[k], e);
            check($sformatf("%s u%0d ovf", tag, k), {95'h0, capo[k]}, {95'h0, eo});
            check($sformatf("%s u%0d latency", tag, k), 96'(lat[k]), 96'(cfg_max(k) + 1));
        end
    endtask

    typedef struct {
        logic [31:0] d;
        logic [95:0] want;
        logic        ovf;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int          cnt;
        logic [95:0] e;
        logic        eo;
        logic [31:0] r;
        logic [31:0] d;

        tbl[0] = '{d: 32'd12345,     want: {32'h0, 24'hFFFFFF, "12345"},         ovf: 1'b0};
        tbl[1] = '{d: 32'd0,         want: {32'h0, 56'hFFFFFFFFFFFFFF, "0"},     ovf: 1'b0};
        tbl[2] = '{d: 32'd123456789, want: {32'h0, "23456789"},                  ovf: 1'b1};
        tbl[3] = '{d: 32'd99999999,  want: {32'h0, "99999999"},                  ovf: 1'b0};
        tbl[4] = '{d: 32'd100000000, want: {32'h0, "00000000"},                  ovf: 1'b1};
        tbl[5] = '{d: 32'hFFFFFFFF,  want: {32'h0, "94967295"},                  ovf: 1'b1};
        tbl[6] = '{d: 32'd7,         want: {32'h0, 56'hFFFFFFFFFFFFFF, "7"},     ovf: 1'b0};
        tbl[7] = '{d: 32'd1000,      want: {32'h0, 32'hFFFFFFFF, "1000"},        ovf: 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        data_in   = '0;
        signed_in = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset in_ready", {92'h0, rdy}, 96'hF);
        check("reset out_valid", {92'h0, ov}, 96'h0);
        check("reset overflow", {92'h0, ofl}, 96'h0);
        check("reset data u0", dout[0], {32'h0, {8{8'hFF}}});
        check("reset data u2", dout[2], {12{8'hFF}});
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_vec(tbl[i].d, 1'b0, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d u0 table data", i), cap[0], tbl[i].want);
            check($sformatf("tbl%0d u0 table ovf", i), {95'h0, capo[0]}, {95'h0, tbl[i].ovf});
        end

        run_vec(32'd0, 1'b0, "zero");
        check("zero lz", cap[1], {32'h0, "00000000"});

        run_vec(32'd5, 1'b0, "frac5");
        check("frac5 u3", cap[3], {32'h0, 32'hFFFFFFFF, "0.05"});
        run_vec(32'd12345, 1'b0, "frac12345");
        check("frac12345 u3", cap[3], {32'h0, 16'hFFFF, "123.45"});

        run_vec(32'hFFFFFFD6, 1'b1, "neg42");
        check("neg42 u0", cap[0], SEN ? {32'h0, 40'hFFFFFFFFFF, "-42"} : {32'h0, "94967254"});
        check("neg42 u1", cap[1], SEN ? {32'h0, "-0000042"} : {32'h0, "94967254"});
        run_vec(32'h80000000, 1'b1, "minint");
        check("minint u2", cap[2], SEN ? {8'hFF, "-2147483648"} : {16'hFFFF, "2147483648"});
        check("minint u2 ovf", {95'h0, capo[2]}, 96'h0);

        for (int i = 0; i < 40; i++) begin
            r = $urandom;
            case ($urandom_range(0, 3))
                0: d = r & 32'hFF;
                1: d = r & 32'hFFFF;
                2: d = r;
                default: d = -(r & 32'hFFF);
            endcase
            run_vec(d, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
        end

        // Backpressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        @(negedge clk);
        data_in   = 32'd777;
        signed_in = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        cnt = 0;
        while (!ov[0] && cnt < 30) begin
            @(negedge clk);
            cnt++;
        end
        model(0, 32'd777, 1'b0, e, eo);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("hold%0d valid", i), {95'h0, ov[0]}, 96'h1);
            check($sformatf("hold%0d data", i), dout[0], e);
            check($sformatf("hold%0d in_ready", i), {95'h0, rdy[0]}, 96'h0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release valid", {95'h0, ov[0]}, 96'h0);
        check("release in_ready", {95'h0, rdy[0]}, 96'h1);

        // Reset in the middle of a conversion.
        repeat (2) @(negedge clk);
        data_in  = 32'd4242;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("conv in_ready", {95'h0, rdy[0]}, 96'h0);
        rst_n = 1'b0;
        #1;
        check("midreset in_ready", {92'h0, rdy}, 96'hF);
        check("midreset out_valid", {92'h0, ov}, 96'h0);
        check("midreset overflow", {92'h0, ofl}, 96'h0);
        check("midreset data u0", dout[0], {32'h0, {8{8'hFF}}});
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(32'd12345, 1'b0, "postreset");
        check("postreset u0", cap[0], {32'h0, 24'hFFFFFF, "12345"});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
